// File: rtl/vga_tex_writer_pkg.sv
// Shared constants and types for the VGA texture-buffer writer.
package vga_tex_writer_pkg;

   localparam logic [31:0] VGA_FB_BASE     = 32'h0000_0400;
   localparam int          VGA_SCREEN_SIZE = 16;

   // Control register offsets relative to the end of the pixel window
   localparam logic [31:0] FB_REG_FILL_VAL   = 32'h0;
   localparam logic [31:0] FB_REG_FILL_START = 32'h4;
   localparam logic [31:0] FB_REG_FILL_COUNT = 32'h8;
   localparam logic [31:0] FB_REG_STATUS     = 32'hC;

   // Index field is generous so any practical screen size fits
   localparam int FB_IDX_W = 16;

   typedef struct packed {
      logic [FB_IDX_W-1:0] idx;
      logic [31:0]         data;
   } fb_wr_t;

   typedef enum logic [0:0] {
      FB_IDLE,
      FB_FILL
   } fb_state_t;

endpackage

// File: rtl/vga_tex_writer_tex_wr_fifo.sv
// Small synchronous FIFO queueing CPU pixel stores ahead of tex[] commit.
// A push while full is accepted when a pop happens on the same edge.
module tex_wr_fifo
   import vga_tex_writer_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic   clk,
   input  logic   rst_n,
   input  logic   i_push,
   input  fb_wr_t i_wr,
   input  logic   i_pop,
   output fb_wr_t o_rd,
   output logic   o_full,
   output logic   o_empty
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   fb_wr_t         r_mem [DEPTH];
   logic [PW-1:0]  r_wp;
   logic [PW-1:0]  r_rp;
   logic [PW:0]    r_cnt;
   logic           w_pop;
   logic           w_push;

   assign o_full  = (r_cnt == (PW+1)'(DEPTH));
   assign o_empty = (r_cnt == '0);
   assign o_rd    = r_mem[r_rp];
   assign w_pop   = i_pop && !o_empty;
   assign w_push  = i_push && (!o_full || w_pop);

   // Pointer and occupancy tracking
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wp  <= '0;
         r_rp  <= '0;
         r_cnt <= '0;
      end else begin
         if (w_push) r_wp <= r_wp + 1'b1;
         if (w_pop)  r_rp <= r_rp + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_cnt <= r_cnt + 1'b1;
            2'b01:   r_cnt <= r_cnt - 1'b1;
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   // Entry storage; contents are don't-care until pushed
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wp] <= i_wr;
   end

endmodule

// File: rtl/vga_tex_writer.sv
// CPU-side writer for the VGA texture buffer: pixel store queue, fill
// engine, control/status registers and the tex[] storage itself.
module vga_tex_writer
   import vga_tex_writer_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR   = VGA_FB_BASE,
   parameter int          N_WORDS     = VGA_SCREEN_SIZE,
   parameter int          FIFO_DEPTH  = 4,
   parameter int          VBLANK_ONLY = 0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        we,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        busy,
   input  logic        vblank_in,
   output logic [31:0] tex [N_WORDS]
);

   localparam int          IDX_W = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
   localparam logic [31:0] CB    = BASE_ADDR + 32'(N_WORDS) * 32'd4;

   fb_state_t      r_state;
   logic [31:0]    r_fill_val;
   logic [31:0]    r_fill_start;
   logic [31:0]    r_fill_count;
   logic           r_ovf;
   logic           r_lerr;
   logic [IDX_W-1:0] r_ptr;
   logic [IDX_W:0]   r_rem;

   logic           w_pix_hit;
   logic [IDX_W-1:0] w_idx;
   logic           w_sel_val, w_sel_start, w_sel_count, w_sel_stat;
   logic           w_commit_ok;
   logic           w_push_req, w_pop, w_full, w_empty;
   fb_wr_t         w_push_data, w_head;
   logic [IDX_W:0] w_avail, w_launch_rem;

   assign w_pix_hit   = (addr >= BASE_ADDR) && (addr < CB) && (addr[1:0] == 2'b00);
   assign w_idx       = IDX_W'((addr - BASE_ADDR) >> 2);
   assign w_sel_val   = (addr == CB + FB_REG_FILL_VAL);
   assign w_sel_start = (addr == CB + FB_REG_FILL_START);
   assign w_sel_count = (addr == CB + FB_REG_FILL_COUNT);
   assign w_sel_stat  = (addr == CB + FB_REG_STATUS);

   assign w_commit_ok = (VBLANK_ONLY == 0) || vblank_in;
   assign w_push_req  = we && w_pix_hit;
   assign w_pop       = !w_empty && (r_state == FB_IDLE) && w_commit_ok;
   assign w_push_data = '{idx: FB_IDX_W'(w_idx), data: wdata};
   assign busy        = (r_state != FB_IDLE) || !w_empty;
   assign w_avail     = (IDX_W+1)'(N_WORDS) - {1'b0, r_fill_start[IDX_W-1:0]};

   tex_wr_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_push_req),
      .i_wr    (w_push_data),
      .i_pop   (w_pop),
      .o_rd    (w_head),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   // Fill length clamped so the fill stops at the last word instead of wrapping
   always_comb begin
      w_launch_rem = '0;
      if (r_fill_start < 32'(N_WORDS)) begin
         if (wdata < 32'(w_avail)) w_launch_rem = wdata[IDX_W:0];
         else                      w_launch_rem = w_avail;
      end
   end

   // Control registers, sticky status flags and the fill FSM
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= FB_IDLE;
         r_fill_val   <= '0;
         r_fill_start <= '0;
         r_fill_count <= '0;
         r_ovf        <= 1'b0;
         r_lerr       <= 1'b0;
         r_ptr        <= '0;
         r_rem        <= '0;
      end else begin
         if (we && w_sel_val)   r_fill_val   <= wdata;
         if (we && w_sel_start) r_fill_start <= wdata;
         if (we && w_sel_stat) begin
            if (wdata[2]) r_ovf  <= 1'b0;
            if (wdata[3]) r_lerr <= 1'b0;
         end
         if (w_push_req && w_full && !w_pop) r_ovf <= 1'b1;
         case (r_state)
            FB_IDLE: begin
               if (we && w_sel_count) begin
                  r_fill_count <= wdata;
                  if (w_launch_rem != '0) begin
                     r_state <= FB_FILL;
                     r_ptr   <= r_fill_start[IDX_W-1:0];
                     r_rem   <= w_launch_rem;
                  end
               end
            end
            FB_FILL: begin
               if (we && w_sel_count) r_lerr <= 1'b1;
               if (w_commit_ok) begin
                  r_ptr <= r_ptr + 1'b1;
                  r_rem <= r_rem - 1'b1;
                  if (r_rem == (IDX_W+1)'(1)) r_state <= FB_IDLE;
               end
            end
            default: r_state <= FB_IDLE;
         endcase
      end
   end

   // Commit mux into tex[]: fill engine owns the array while filling, else the queue drains
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_WORDS; i++) tex[i] <= '0;
      end else if ((r_state == FB_FILL) && w_commit_ok) begin
         tex[r_ptr] <= r_fill_val;
      end else if (w_pop) begin
         tex[IDX_W'(w_head.idx)] <= w_head.data;
      end
   end

   // Read-back returns committed state only
   always_comb begin
      rdata = '0;
      if (w_pix_hit)        rdata = tex[w_idx];
      else if (w_sel_val)   rdata = r_fill_val;
      else if (w_sel_start) rdata = r_fill_start;
      else if (w_sel_count) rdata = r_fill_count;
      else if (w_sel_stat)  rdata = {28'd0, r_lerr, r_ovf, w_full, busy};
   end

endmodule

// File: tb/tb_vga_tex_writer.sv
// Directed bench for vga_tex_writer: one instance commits freely, the
// other only during vertical blank.
module tb_vga_tex_writer;

   localparam int          N       = 16;
   localparam logic [31:0] BASE    = 32'h0000_0400;
   localparam logic [31:0] A_VAL   = 32'h0000_0440;
   localparam logic [31:0] A_START = 32'h0000_0444;
   localparam logic [31:0] A_COUNT = 32'h0000_0448;
   localparam logic [31:0] A_STAT  = 32'h0000_044C;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        we0, vb0, busy0;
   logic [31:0] addr0, wdata0, rdata0;
   logic [31:0] tex0 [N];
   logic        we1, vb1, busy1;
   logic [31:0] addr1, wdata1, rdata1;
   logic [31:0] tex1 [N];

   int n_chk  = 0;
   int n_fail = 0;
   int n;
   logic [31:0] rv;

   always #5 clk = ~clk;

   vga_tex_writer #(.BASE_ADDR(BASE), .N_WORDS(N), .FIFO_DEPTH(4), .VBLANK_ONLY(0)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .we(we0), .addr(addr0), .wdata(wdata0),
      .rdata(rdata0), .busy(busy0), .vblank_in(vb0), .tex(tex0)
   );

   vga_tex_writer #(.BASE_ADDR(BASE), .N_WORDS(N), .FIFO_DEPTH(4), .VBLANK_ONLY(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .we(we1), .addr(addr1), .wdata(wdata1),
      .rdata(rdata1), .busy(busy1), .vblank_in(vb1), .tex(tex1)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic wr0(input logic [31:0] a, input logic [31:0] d);
      we0 = 1'b1; addr0 = a; wdata0 = d;
      @(negedge clk);
      we0 = 1'b0;
   endtask

   task automatic wr1(input logic [31:0] a, input logic [31:0] d);
      we1 = 1'b1; addr1 = a; wdata1 = d;
      @(negedge clk);
      we1 = 1'b0;
   endtask

   task automatic rd0(input logic [31:0] a, output logic [31:0] d);
      addr0 = a; #1; d = rdata0;
   endtask

   task automatic rd1(input logic [31:0] a, output logic [31:0] d);
      addr1 = a; #1; d = rdata1;
   endtask

   task automatic wait_idle0(output int cyc);
      cyc = 0;
      while (busy0 && cyc < 200) begin @(negedge clk); cyc++; end
   endtask

   task automatic wait_idle1(output int cyc);
      cyc = 0;
      while (busy1 && cyc < 200) begin @(negedge clk); cyc++; end
   endtask

   initial begin
      rst_n = 1'b0;
      we0 = 1'b0; addr0 = '0; wdata0 = '0; vb0 = 1'b0;
      we1 = 1'b0; addr1 = '0; wdata1 = '0; vb1 = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_tex0_0", tex0[0], 32'h0);
      chk("rst_tex0_15", tex0[15], 32'h0);
      chk("rst_busy0", 32'(busy0), 32'h0);
      rd0(A_STAT, rv); chk("rst_status0", rv, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // single pixel store: one-edge latency, one-cycle busy pulse
      wr0(BASE + 32'd8, 32'h00FF_00FF);
      chk("st_busy_hi", 32'(busy0), 32'h1);
      chk("st_tex2_pre", tex0[2], 32'h0);
      wait_idle0(n);
      chk("st_busy_len", 32'(n), 32'd1);
      chk("st_tex2", tex0[2], 32'h00FF_00FF);
      rd0(BASE + 32'd8, rv); chk("st_rd2", rv, 32'h00FF_00FF);

      // last write to an index wins
      wr0(BASE + 32'd20, 32'h1);
      wr0(BASE + 32'd20, 32'h2);
      wait_idle0(n);
      chk("lww_tex5", tex0[5], 32'h2);

      // undecoded addresses
      wr0(32'h0000_0500, 32'hDEAD_BEEF);
      chk("oor_busy", 32'(busy0), 32'h0);
      rd0(32'h0000_0500, rv); chk("oor_rd", rv, 32'h0);

      // full-screen fill
      wr0(A_VAL, 32'hFFFF_FFFF);
      wr0(A_START, 32'd0);
      wr0(A_COUNT, 32'd16);
      wait_idle0(n);
      chk("fill_busy_len", 32'(n), 32'd16);
      for (int i = 0; i < N; i++) chk($sformatf("fill_tex%0d", i), tex0[i], 32'hFFFF_FFFF);
      rd0(A_STAT, rv);  chk("fill_status", rv, 32'h0);
      rd0(A_VAL, rv);   chk("fill_rd_val", rv, 32'hFFFF_FFFF);
      rd0(A_COUNT, rv); chk("fill_rd_count", rv, 32'd16);

      // clamped fill at the end of the buffer
      wr0(A_VAL, 32'h1234_5678);
      wr0(A_START, 32'd14);
      wr0(A_COUNT, 32'd10);
      wait_idle0(n);
      chk("clamp_busy_len", 32'(n), 32'd2);
      chk("clamp_tex14", tex0[14], 32'h1234_5678);
      chk("clamp_tex15", tex0[15], 32'h1234_5678);
      chk("clamp_tex13", tex0[13], 32'hFFFF_FFFF);
      chk("clamp_tex0", tex0[0], 32'hFFFF_FFFF);

      // no-op launches
      wr0(A_START, 32'd20);
      wr0(A_COUNT, 32'd5);
      chk("noop_start_busy", 32'(busy0), 32'h0);
      wr0(A_START, 32'd0);
      wr0(A_COUNT, 32'd0);
      chk("noop_zero_busy", 32'(busy0), 32'h0);

      // relaunch during fill, pixel store queued behind the fill
      wr0(A_VAL, 32'hA5A5_A5A5);
      wr0(A_COUNT, 32'd16);
      wr0(A_COUNT, 32'd5);
      wr0(BASE + 32'd12, 32'h0000_DEAD);
      rd0(A_STAT, rv); chk("lerr_status", rv, 32'h9);
      wait_idle0(n);
      chk("lerr_busy_len", 32'(n), 32'd15);
      chk("lerr_tex3", tex0[3], 32'h0000_DEAD);
      chk("lerr_tex4", tex0[4], 32'hA5A5_A5A5);
      chk("lerr_tex15", tex0[15], 32'hA5A5_A5A5);
      rd0(A_STAT, rv); chk("lerr_sticky", rv, 32'h8);
      wr0(A_STAT, 32'h8);
      rd0(A_STAT, rv); chk("lerr_w1c", rv, 32'h0);

      // vblank-gated instance: overflow then ordered drain
      for (int k = 0; k < 5; k++) wr1(BASE + 32'(4 * k), 32'h10 + 32'(k));
      rd1(A_STAT, rv); chk("vb_status_full", rv, 32'h7);
      chk("vb_tex0_held", tex1[0], 32'h0);
      vb1 = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk($sformatf("vb_drain%0d", k), tex1[k], 32'h10 + 32'(k));
         if (k < 3) chk($sformatf("vb_next%0d", k), tex1[k + 1], 32'h0);
      end
      chk("vb_busy_done", 32'(busy1), 32'h0);
      chk("vb_tex4_dropped", tex1[4], 32'h0);
      vb1 = 1'b0;
      rd1(A_STAT, rv); chk("vb_ovf_sticky", rv, 32'h4);
      wr1(A_STAT, 32'h4);
      rd1(A_STAT, rv); chk("vb_ovf_w1c", rv, 32'h0);

      // push and pop on the same edge while full
      for (int k = 0; k < 4; k++) wr1(BASE + 32'(4 * (6 + k)), 32'h20 + 32'(k));
      rd1(A_STAT, rv); chk("pp_status_full", rv, 32'h3);
      vb1 = 1'b1;
      wr1(BASE + 32'd40, 32'h2A);
      wait_idle1(n);
      chk("pp_drain_len", 32'(n), 32'd4);
      chk("pp_tex6", tex1[6], 32'h20);
      chk("pp_tex9", tex1[9], 32'h23);
      chk("pp_tex10", tex1[10], 32'h2A);
      rd1(A_STAT, rv); chk("pp_no_ovf", rv, 32'h0);
      vb1 = 1'b0;

      // asynchronous reset in the middle of a fill
      wr0(A_VAL, 32'h55);
      wr0(A_COUNT, 32'd16);
      repeat (3) @(negedge clk);
      chk("mid_busy", 32'(busy0), 32'h1);
      chk("mid_tex0", tex0[0], 32'h55);
      #2;
      rst_n = 1'b0;
      addr0 = A_STAT;
      #1;
      chk("arst_tex0", tex0[0], 32'h0);
      chk("arst_tex1", tex0[1], 32'h0);
      chk("arst_busy", 32'(busy0), 32'h0);
      chk("arst_status", rdata0, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
